// File: rtl/seq_wide_adder_pkg.sv
// ----------------------------------------------------------------------------
// seq_wide_adder_pkg
//   Shared definitions for the sequential wide adder:
//     CHUNK_W  width of one ripple-carry slice pass (4 bits)
//     state_e  control FSM encoding (IDLE / RUN / DONE, 2 bits)
// ----------------------------------------------------------------------------
package seq_wide_adder_pkg;

    localparam int CHUNK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : seq_wide_adder_pkg

// File: rtl/seq_wide_adder_rca.sv
// ----------------------------------------------------------------------------
// seq_wide_adder_rca
//   Purely combinational CHUNK_W-bit ripple-carry adder slice.
//   Ports:
//     a, b   in   CHUNK_W  operand chunks
//     cin    in   1        carry into bit 0
//     sum    out  CHUNK_W  a + b + cin (low CHUNK_W bits)
//     carry  out  1        carry out of the top bit
// ----------------------------------------------------------------------------
module seq_wide_adder_rca
    import seq_wide_adder_pkg::*;
(
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               cin,
    output logic [CHUNK_W-1:0] sum,
    output logic               carry
);

    // c[i] is the carry into bit i; c[CHUNK_W] leaves the slice.
    logic [CHUNK_W:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < CHUNK_W; gi++) begin : g_bit
            assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign carry = c[CHUNK_W];

endmodule : seq_wide_adder_rca

// File: rtl/seq_wide_adder.sv
// ----------------------------------------------------------------------------
// seq_wide_adder
//   Multi-cycle WIDTH-bit adder. Operands are captured on an in_valid/in_ready
//   handshake, then one CHUNK_W-bit chunk per cycle (LSB first) is pushed
//   through a single ripple-carry slice, with the slice carry held in a
//   register between passes. The result is offered on out_valid/out_ready.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst        in   1      synchronous active-high reset
//     in_valid   in   1      operands valid
//     in_ready   out  1      operands can be accepted (IDLE only)
//     a, b       in   WIDTH  operands
//     cin        in   1      carry into chunk 0
//     out_valid  out  1      sum/cout valid (DONE)
//     out_ready  in   1      consumer takes the result
//     sum        out  WIDTH  a + b + cin mod 2^WIDTH
//     cout       out  1      carry out of the MSB chunk
//     busy       out  1      operation in flight or result pending
// ----------------------------------------------------------------------------
module seq_wide_adder
    import seq_wide_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK_W) != 0 || WIDTH < CHUNK_W) begin : g_width_check
            $error("seq_wide_adder: WIDTH (%0d) must be a positive multiple of %0d",
                   WIDTH, CHUNK_W);
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q;
    logic               cout_q;
    logic [IDX_W-1:0]   idx_q;

    // Operand chunks as arrays so the slice mux is a plain index by idx_q.
    logic [CHUNK_W-1:0] a_chunk [NCHUNK];
    logic [CHUNK_W-1:0] b_chunk [NCHUNK];

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign a_chunk[gi] = a_q[gi*CHUNK_W +: CHUNK_W];
            assign b_chunk[gi] = b_q[gi*CHUNK_W +: CHUNK_W];
        end
    endgenerate

    logic [CHUNK_W-1:0] slice_a, slice_b, slice_sum;
    logic               slice_carry;

    assign slice_a = a_chunk[idx_q];
    assign slice_b = b_chunk[idx_q];

    seq_wide_adder_rca u_rca (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry_q),
        .sum   (slice_sum),
        .carry (slice_carry)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_valid)           state_d = ST_RUN;
            ST_RUN:  if (idx_q == LAST_IDX)  state_d = ST_DONE;
            ST_DONE: if (out_ready)          state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            ST_IDLE: in_ready  = 1'b1;
            ST_RUN:  busy      = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready  = 1'b0;
        endcase
    end

    // Merge the current slice result into the chunk selected by idx_q.
    always_comb begin
        sum_d = sum_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sum_d[i*CHUNK_W +: CHUNK_W] = slice_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        // Cleared so unwritten chunks read 0 while running.
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= slice_carry;
                    if (idx_q == LAST_IDX) begin
                        cout_q <= slice_carry;
                    end else begin
                        idx_q  <= idx_q + 1'b1;
                    end
                end
                default: begin
                    // DONE: result held until the consumer takes it.
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : seq_wide_adder
